lc4_regfile_2w4r: RTL and testbench
===================================

Name: lc4_regfile_2w4r

Overview:
Next-generation LC4 register file for the dual-issue pipeline. It is parametrised in word width and register count, with two write ports (pipe A, pipe B) and four read ports (rs/rt for each pipe). A per-register busy scoreboard tracks in-flight producers for hazard detection. Write-to-read bypass is compile-time optional. It sits in decode/writeback and replaces the single-write, 8-register file.

Parameters:
n, 16, data word width in bits
NREGS, 8, number of architectural registers (power of 2, ≥2)
SELW, $clog2(NREGS), register selector width (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
gwe  in  1  global write enable; gates every state update
i_rs_a, i_rt_a, i_rs_b, i_rt_b  in  SELW  read selectors
o_rs_a_data, o_rt_a_data, o_rs_b_data, o_rt_b_data  out  n  read data
o_rs_a_busy, o_rt_a_busy, o_rs_b_busy, o_rt_b_busy  out  1  busy bit of selected register
i_rd_a, i_rd_b  in  SELW  write selectors
i_wdata_a, i_wdata_b  in  n  write data
i_we_a, i_we_b  in  1  write enables
i_bset_a, i_bset_b  in  1  mark register busy
i_bsel_a, i_bsel_b  in  SELW  register to mark busy

Behaviour:
- State: NREGS×n data registers; NREGS busy bits. All update only on rising clk with gwe=1. When gwe=0, state holds.
- Reset: rst=0 at a clk edge clears all data and busy bits to 0. Reset wins over every write or busy-set in that cycle, regardless of gwe. After reset, every read output is 0 and every busy output is 0.
- Write: i_we_x=1 → reg[i_rd_x] ← i_wdata_x at the edge.
- Both ports write the same register in one cycle: port B (younger) wins. Different registers: both are written.
- Busy clear: an effective write to register r clears busy[r].
- Busy set: i_bset_x=1 sets busy[i_bsel_x].
- Set and clear of the same register in one cycle: set wins, because the new producer is younger.
- Busy sets from both ports are independent. They are OR-combined on the same register.
- Reads: combinational, zero latency. Without bypass, reads return the pre-edge register contents.
- Busy outputs are combinational from the busy bits, except for bypass forwarding (see Optional Feature).
- Index range: all selectors are in range by construction (SELW bits, NREGS power of 2).
- No register is hard-wired to zero.

Optional Feature:
Macro: LC4_RF_BYPASS_EN.
Defined:
- A read whose selector matches an active write port (i_we_x=1, gwe=1) returns that port's i_wdata in the same cycle. If both ports match, B's data is returned.
- The matching read's busy output is 0, unless a busy-set to the same register is active that cycle, in which case it is 1.
Undefined:
- Reads and busy outputs reflect stored state only.
- Forwarded values appear one cycle after the write.

Decomposition:
- Shared package lc4_rf_pkg: default width 16, default NREGS 8, and the selector-width function.
- Natural sub-module: lc4_rf_rdport, one combinational read mux plus optional bypass compare. It is instantiated four times.
- Storage uses existing Nbit_reg-style cells or an equivalent flop array. The write-port priority mux is local.

Test Plan:
- Reset: write 0x1234 to R3, then assert rst=0 for one edge → all four reads of R3 give 0x0000; all busy = 0.
- Dual write, different registers: A writes R1=0x00AA, B writes R6=0xBEEF in one cycle → next cycle rs_a=R1 reads 0x00AA, rt_b=R6 reads 0xBEEF.
- Write collision: A and B both write R2 (0x1111 and 0x2222) → R2 reads 0x2222.
- gwe hold: gwe=0 with we_a=1 writing R4=0x5555 → R4 stays at its prior value; bset on R4 is ignored.
- Scoreboard:
  - bset_a on R5 → next cycle busy=1.
  - Then write R5=0x0777 with bset_b on R5 in the same cycle → busy stays 1, data reads 0x0777.
  - Then a plain write → busy returns to 0.
- Bypass:
  - With LC4_RF_BYPASS_EN, write R7=0xCAFE while reading R7 → same-cycle read gives 0xCAFE and busy 0.
  - Without the macro → same-cycle read gives the old value; next cycle gives 0xCAFE.

Source files
------------

// File: rtl/lc4_rf_pkg.sv
// lc4_rf_pkg: shared defaults and selector-width helper for the LC4 register file
package lc4_rf_pkg;
    localparam int RF_WIDTH = 16;
    localparam int RF_NREGS = 8;
    function automatic int sel_width(input int nregs);
        return $clog2(nregs);
    endfunction
endpackage

// File: rtl/lc4_rf_rdport.sv
// lc4_rf_rdport: one combinational read mux, with same-cycle write forwarding when LC4_RF_BYPASS_EN is defined
module lc4_rf_rdport
    import lc4_rf_pkg::*;
#(
    parameter int n = RF_WIDTH,
    parameter int NREGS = RF_NREGS,
    localparam int SELW = sel_width(NREGS)
) (
    input  logic [SELW-1:0]          sel,
    input  logic [NREGS-1:0][n-1:0]  regs,
    input  logic [NREGS-1:0]         busy,
`ifdef LC4_RF_BYPASS_EN
    input  logic                     we_a,
    input  logic                     we_b,
    input  logic [SELW-1:0]          rd_a,
    input  logic [SELW-1:0]          rd_b,
    input  logic [n-1:0]             wdata_a,
    input  logic [n-1:0]             wdata_b,
    input  logic [NREGS-1:0]         bset,
`endif
    output logic [n-1:0]             data,
    output logic                     sel_busy
);
`ifdef LC4_RF_BYPASS_EN
    logic hit_a, hit_b;
    // forward the youngest matching write; a forwarded value is busy only if re-claimed this cycle
    always_comb begin
        hit_a = we_a && rd_a == sel;
        hit_b = we_b && rd_b == sel;
        data = hit_b ? wdata_b : hit_a ? wdata_a : regs[sel];
        sel_busy = (hit_a || hit_b) ? bset[sel] : busy[sel];
    end
`else
    // stored state only; writes become visible after the edge
    always_comb begin
        data = regs[sel];
        sel_busy = busy[sel];
    end
`endif
endmodule

// File: rtl/lc4_regfile_2w4r.sv
// lc4_regfile_2w4r: dual-write, quad-read LC4 register file with busy scoreboard (bypass via LC4_RF_BYPASS_EN)
module lc4_regfile_2w4r
    import lc4_rf_pkg::*;
#(
    parameter int n = RF_WIDTH,
    parameter int NREGS = RF_NREGS,
    localparam int SELW = sel_width(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            gwe,
    input  logic [SELW-1:0] i_rs_a,
    input  logic [SELW-1:0] i_rt_a,
    input  logic [SELW-1:0] i_rs_b,
    input  logic [SELW-1:0] i_rt_b,
    output logic [n-1:0]    o_rs_a_data,
    output logic [n-1:0]    o_rt_a_data,
    output logic [n-1:0]    o_rs_b_data,
    output logic [n-1:0]    o_rt_b_data,
    output logic            o_rs_a_busy,
    output logic            o_rt_a_busy,
    output logic            o_rs_b_busy,
    output logic            o_rt_b_busy,
    input  logic [SELW-1:0] i_rd_a,
    input  logic [SELW-1:0] i_rd_b,
    input  logic [n-1:0]    i_wdata_a,
    input  logic [n-1:0]    i_wdata_b,
    input  logic            i_we_a,
    input  logic            i_we_b,
    input  logic            i_bset_a,
    input  logic            i_bset_b,
    input  logic [SELW-1:0] i_bsel_a,
    input  logic [SELW-1:0] i_bsel_b
);
    logic [NREGS-1:0][n-1:0] regs;
    logic [NREGS-1:0]        busy, wr_a, wr_b, set;
    logic                    we_a, we_b;
    logic [SELW-1:0]         rsel  [4];
    logic [n-1:0]            rdata [4];
    logic                    rbusy [4];

    assign we_a = gwe && i_we_a;
    assign we_b = gwe && i_we_b;

    // one-hot write and busy-set decodes, already qualified by gwe
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            wr_a[i] = we_a && i_rd_a == SELW'(i);
            wr_b[i] = we_b && i_rd_b == SELW'(i);
            set[i]  = gwe && ((i_bset_a && i_bsel_a == SELW'(i)) || (i_bset_b && i_bsel_b == SELW'(i)));
        end
    end

    // storage: port B beats port A on the same register; a new claim beats a completing write
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs <= '0;
            busy <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                if (wr_b[i] || wr_a[i]) regs[i] <= wr_b[i] ? i_wdata_b : i_wdata_a;
            busy <= set | (busy & ~(wr_a | wr_b));
        end
    end

    assign rsel = '{i_rs_a, i_rt_a, i_rs_b, i_rt_b};

    genvar p;
    generate
        for (p = 0; p < 4; p++) begin : g_rd
            lc4_rf_rdport #(.n(n), .NREGS(NREGS)) u_rd (
                .sel(rsel[p]),
                .regs(regs),
                .busy(busy),
`ifdef LC4_RF_BYPASS_EN
                .we_a(we_a),
                .we_b(we_b),
                .rd_a(i_rd_a),
                .rd_b(i_rd_b),
                .wdata_a(i_wdata_a),
                .wdata_b(i_wdata_b),
                .bset(set),
`endif
                .data(rdata[p]),
                .sel_busy(rbusy[p])
            );
        end
    endgenerate

    assign o_rs_a_data = rdata[0];
    assign o_rt_a_data = rdata[1];
    assign o_rs_b_data = rdata[2];
    assign o_rt_b_data = rdata[3];
    assign o_rs_a_busy = rbusy[0];
    assign o_rt_a_busy = rbusy[1];
    assign o_rs_b_busy = rbusy[2];
    assign o_rt_b_busy = rbusy[3];
endmodule

// File: tb/tb_lc4_regfile_2w4r.sv
// tb_lc4_regfile_2w4r: directed and randomized checks of the register file against an array model
module tb_lc4_regfile_2w4r;
    localparam int n = 16;
    localparam int NREGS = 8;
    localparam int SELW = 3;

    logic clk = 0, rst = 0, gwe = 1;
    logic [SELW-1:0] i_rs_a = 0, i_rt_a = 0, i_rs_b = 0, i_rt_b = 0;
    logic [SELW-1:0] i_rd_a = 0, i_rd_b = 0, i_bsel_a = 0, i_bsel_b = 0;
    logic [n-1:0] i_wdata_a = 0, i_wdata_b = 0;
    logic i_we_a = 0, i_we_b = 0, i_bset_a = 0, i_bset_b = 0;
    logic [n-1:0] o_rs_a_data, o_rt_a_data, o_rs_b_data, o_rt_b_data;
    logic o_rs_a_busy, o_rt_a_busy, o_rs_b_busy, o_rt_b_busy;

    int nchk = 0, nfail = 0;
    logic [n-1:0] mem [NREGS];
    logic bsy [NREGS];

    lc4_regfile_2w4r #(.n(n), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst), .gwe(gwe),
        .i_rs_a(i_rs_a), .i_rt_a(i_rt_a), .i_rs_b(i_rs_b), .i_rt_b(i_rt_b),
        .o_rs_a_data(o_rs_a_data), .o_rt_a_data(o_rt_a_data),
        .o_rs_b_data(o_rs_b_data), .o_rt_b_data(o_rt_b_data),
        .o_rs_a_busy(o_rs_a_busy), .o_rt_a_busy(o_rt_a_busy),
        .o_rs_b_busy(o_rs_b_busy), .o_rt_b_busy(o_rt_b_busy),
        .i_rd_a(i_rd_a), .i_rd_b(i_rd_b), .i_wdata_a(i_wdata_a), .i_wdata_b(i_wdata_b),
        .i_we_a(i_we_a), .i_we_b(i_we_b), .i_bset_a(i_bset_a), .i_bset_b(i_bset_b),
        .i_bsel_a(i_bsel_a), .i_bsel_b(i_bsel_b)
    );

    always #5 clk = ~clk;

    // expected read value: stored word, or the youngest same-cycle write when forwarding is built in
    function automatic logic [n-1:0] exp_data(input logic [SELW-1:0] s);
`ifdef LC4_RF_BYPASS_EN
        if (gwe && i_we_b && i_rd_b == s) return i_wdata_b;
        if (gwe && i_we_a && i_rd_a == s) return i_wdata_a;
`endif
        return mem[s];
    endfunction

    function automatic logic exp_busy(input logic [SELW-1:0] s);
`ifdef LC4_RF_BYPASS_EN
        if (gwe && ((i_we_a && i_rd_a == s) || (i_we_b && i_rd_b == s)))
            return gwe && ((i_bset_a && i_bsel_a == s) || (i_bset_b && i_bsel_b == s));
`endif
        return bsy[s];
    endfunction

    task automatic quiet();
        rst = 1; gwe = 1; i_we_a = 0; i_we_b = 0; i_bset_a = 0; i_bset_b = 0;
    endtask

    task automatic read_all(input logic [SELW-1:0] s);
        i_rs_a = s; i_rt_a = s; i_rs_b = s; i_rt_b = s;
    endtask

    // one clock: the model applies the architectural rules in age order, then inputs return at negedge
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin mem[i] = 0; bsy[i] = 0; end
        end else if (gwe) begin
            if (i_we_a) begin mem[i_rd_a] = i_wdata_a; bsy[i_rd_a] = 0; end
            if (i_we_b) begin mem[i_rd_b] = i_wdata_b; bsy[i_rd_b] = 0; end
            if (i_bset_a) bsy[i_bsel_a] = 1;
            if (i_bset_b) bsy[i_bsel_b] = 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 0; tick(); tick();
        quiet(); i_we_a = 1; i_rd_a = 3; i_wdata_a = 16'h1234; i_bset_b = 1; i_bsel_b = 3; tick();
        quiet(); rst = 0; i_we_b = 1; i_rd_b = 3; i_wdata_b = 16'h9999; tick();
        quiet(); read_all(3); #1;
        nchk++; if (o_rs_a_data !== 16'h0) begin nfail++; $display("FAIL reset rs_a_data got=%h exp=0000", o_rs_a_data); end
        nchk++; if (o_rt_a_data !== 16'h0) begin nfail++; $display("FAIL reset rt_a_data got=%h exp=0000", o_rt_a_data); end
        nchk++; if (o_rs_b_data !== 16'h0) begin nfail++; $display("FAIL reset rs_b_data got=%h exp=0000", o_rs_b_data); end
        nchk++; if (o_rt_b_data !== 16'h0) begin nfail++; $display("FAIL reset rt_b_data got=%h exp=0000", o_rt_b_data); end
        nchk++; if ({o_rs_a_busy, o_rt_a_busy, o_rs_b_busy, o_rt_b_busy} !== 4'b0) begin
            nfail++; $display("FAIL reset busy got=%b exp=0000", {o_rs_a_busy, o_rt_a_busy, o_rs_b_busy, o_rt_b_busy}); end
    endtask

    task automatic test_dual_write();
        quiet(); i_we_a = 1; i_rd_a = 1; i_wdata_a = 16'h00AA; i_we_b = 1; i_rd_b = 6; i_wdata_b = 16'hBEEF; tick();
        quiet(); i_rs_a = 1; i_rt_b = 6; #1;
        nchk++; if (o_rs_a_data !== 16'h00AA) begin nfail++; $display("FAIL dual_write R1 got=%h exp=00aa", o_rs_a_data); end
        nchk++; if (o_rt_b_data !== 16'hBEEF) begin nfail++; $display("FAIL dual_write R6 got=%h exp=beef", o_rt_b_data); end
    endtask

    task automatic test_collision();
        quiet(); i_we_a = 1; i_rd_a = 2; i_wdata_a = 16'h1111; i_we_b = 1; i_rd_b = 2; i_wdata_b = 16'h2222; tick();
        quiet(); read_all(2); #1;
        nchk++; if (o_rt_a_data !== 16'h2222) begin nfail++; $display("FAIL collision R2 got=%h exp=2222", o_rt_a_data); end
    endtask

    task automatic test_gwe_hold();
        quiet(); i_we_a = 1; i_rd_a = 4; i_wdata_a = 16'h4444; tick();
        quiet(); gwe = 0; i_we_a = 1; i_rd_a = 4; i_wdata_a = 16'h5555; i_bset_a = 1; i_bsel_a = 4; read_all(4); #1;
        nchk++; if (o_rs_b_data !== 16'h4444) begin nfail++; $display("FAIL gwe_same_cycle R4 got=%h exp=4444", o_rs_b_data); end
        tick();
        quiet(); read_all(4); #1;
        nchk++; if (o_rs_a_data !== 16'h4444) begin nfail++; $display("FAIL gwe_hold R4 got=%h exp=4444", o_rs_a_data); end
        nchk++; if (o_rs_a_busy !== 1'b0) begin nfail++; $display("FAIL gwe_hold busy got=%b exp=0", o_rs_a_busy); end
    endtask

    task automatic test_scoreboard();
        quiet(); i_bset_a = 1; i_bsel_a = 5; tick();
        quiet(); read_all(5); #1;
        nchk++; if (o_rt_b_busy !== 1'b1) begin nfail++; $display("FAIL sb_set busy got=%b exp=1", o_rt_b_busy); end
        i_we_a = 1; i_rd_a = 5; i_wdata_a = 16'h0777; i_bset_b = 1; i_bsel_b = 5; tick();
        quiet(); read_all(5); #1;
        nchk++; if (o_rs_a_busy !== 1'b1) begin nfail++; $display("FAIL sb_set_wins busy got=%b exp=1", o_rs_a_busy); end
        nchk++; if (o_rs_a_data !== 16'h0777) begin nfail++; $display("FAIL sb_set_wins data got=%h exp=0777", o_rs_a_data); end
        i_we_b = 1; i_rd_b = 5; i_wdata_b = 16'h0888; tick();
        quiet(); read_all(5); #1;
        nchk++; if (o_rt_a_busy !== 1'b0) begin nfail++; $display("FAIL sb_clear busy got=%b exp=0", o_rt_a_busy); end
        nchk++; if (o_rt_a_data !== 16'h0888) begin nfail++; $display("FAIL sb_clear data got=%h exp=0888", o_rt_a_data); end
        i_bset_a = 1; i_bsel_a = 0; i_bset_b = 1; i_bsel_b = 7; tick();
        quiet(); i_rs_a = 0; i_rs_b = 7; #1;
        nchk++; if ({o_rs_a_busy, o_rs_b_busy} !== 2'b11) begin nfail++; $display("FAIL sb_dual_set got=%b exp=11", {o_rs_a_busy, o_rs_b_busy}); end
    endtask

    task automatic test_bypass();
        quiet(); i_we_a = 1; i_rd_a = 7; i_wdata_a = 16'h0007; tick();
        quiet(); i_bset_a = 1; i_bsel_a = 7; tick();
        quiet(); i_we_a = 1; i_rd_a = 7; i_wdata_a = 16'hCAFE; read_all(7); #1;
`ifdef LC4_RF_BYPASS_EN
        nchk++; if (o_rs_a_data !== 16'hCAFE) begin nfail++; $display("FAIL bypass data got=%h exp=cafe", o_rs_a_data); end
        nchk++; if (o_rs_a_busy !== 1'b0) begin nfail++; $display("FAIL bypass busy got=%b exp=0", o_rs_a_busy); end
`else
        nchk++; if (o_rs_a_data !== 16'h0007) begin nfail++; $display("FAIL nobypass data got=%h exp=0007", o_rs_a_data); end
        nchk++; if (o_rs_a_busy !== 1'b1) begin nfail++; $display("FAIL nobypass busy got=%b exp=1", o_rs_a_busy); end
`endif
        tick();
        quiet(); read_all(7); #1;
        nchk++; if (o_rt_b_data !== 16'hCAFE) begin nfail++; $display("FAIL bypass_next data got=%h exp=cafe", o_rt_b_data); end
        nchk++; if (o_rt_b_busy !== 1'b0) begin nfail++; $display("FAIL bypass_next busy got=%b exp=0", o_rt_b_busy); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) != 0);
            gwe = ($urandom_range(0, 3) != 0);
            i_we_a = $urandom_range(0, 1); i_we_b = $urandom_range(0, 1);
            i_bset_a = ($urandom_range(0, 2) == 0); i_bset_b = ($urandom_range(0, 2) == 0);
            i_rd_a = SELW'($urandom); i_rd_b = SELW'($urandom);
            i_bsel_a = SELW'($urandom); i_bsel_b = SELW'($urandom);
            i_wdata_a = n'($urandom); i_wdata_b = n'($urandom);
            i_rs_a = SELW'($urandom); i_rt_a = SELW'($urandom);
            i_rs_b = SELW'($urandom); i_rt_b = SELW'($urandom);
            #1;
            nchk++; if (o_rs_a_data !== exp_data(i_rs_a) || o_rs_a_busy !== exp_busy(i_rs_a)) begin nfail++;
                $display("FAIL rand rs_a c=%0d sel=%0d got=%h/%b exp=%h/%b", c, i_rs_a, o_rs_a_data, o_rs_a_busy, exp_data(i_rs_a), exp_busy(i_rs_a)); end
            nchk++; if (o_rt_a_data !== exp_data(i_rt_a) || o_rt_a_busy !== exp_busy(i_rt_a)) begin nfail++;
                $display("FAIL rand rt_a c=%0d sel=%0d got=%h/%b exp=%h/%b", c, i_rt_a, o_rt_a_data, o_rt_a_busy, exp_data(i_rt_a), exp_busy(i_rt_a)); end
            nchk++; if (o_rs_b_data !== exp_data(i_rs_b) || o_rs_b_busy !== exp_busy(i_rs_b)) begin nfail++;
                $display("FAIL rand rs_b c=%0d sel=%0d got=%h/%b exp=%h/%b", c, i_rs_b, o_rs_b_data, o_rs_b_busy, exp_data(i_rs_b), exp_busy(i_rs_b)); end
            nchk++; if (o_rt_b_data !== exp_data(i_rt_b) || o_rt_b_busy !== exp_busy(i_rt_b)) begin nfail++;
                $display("FAIL rand rt_b c=%0d sel=%0d got=%h/%b exp=%h/%b", c, i_rt_b, o_rt_b_data, o_rt_b_busy, exp_data(i_rt_b), exp_busy(i_rt_b)); end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) begin mem[i] = 0; bsy[i] = 0; end
        @(negedge clk);
        test_reset();
        test_dual_write();
        test_collision();
        test_gwe_hold();
        test_scoreboard();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
